// File: rtl/line_buffer_pkg.sv
// line_buffer_pkg: shared state encoding and widths for the line-buffer front end
package line_buffer_pkg;
    localparam int COORD_W       = 12;
    localparam int MIN_WIDTH_DEF = 3;
    localparam int STAT_W        = 16;
    typedef enum logic [1:0] {IDLE, FLUSH, ACTIVE, DONE} state_t;
endpackage

// File: rtl/line_buffer_sequencer_if.sv
// line_buffer_sequencer_if: pixel input stream plus the line-buffer drive bus
// in_valid/in_data: raw pixel stream into the sequencer
// lb_*: reset_n, size, valid, data, x, y, done towards the line buffer
interface line_buffer_sequencer_if
    import line_buffer_pkg::*;
#(
    parameter int N = 8
);
    logic               in_valid;
    logic [N-1:0]       in_data;
    logic               lb_reset_n;
    logic [COORD_W-1:0] lb_size;
    logic               lb_valid;
    logic [N-1:0]       lb_data;
    logic [COORD_W-1:0] lb_x;
    logic [COORD_W-1:0] lb_y;
    logic               lb_done;
    modport master (output in_valid, in_data,
                    input  lb_reset_n, lb_size, lb_valid, lb_data, lb_x, lb_y, lb_done);
    modport slave  (input  in_valid, in_data,
                    output lb_reset_n, lb_size, lb_valid, lb_data, lb_x, lb_y, lb_done);
endinterface

// File: rtl/line_buffer_sequencer_raster_counter.sv
// raster_counter: x/y raster position with width/height wrap and last-pixel flag
// clear_i: return to (0,0); step_i: advance one pixel
// width_i/height_i: frame dimensions; x_o/y_o: current position
// last_o: current position is (width-1, height-1)
module raster_counter #(
    parameter int W = 12
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         clear_i,
    input  logic         step_i,
    input  logic [W-1:0] width_i,
    input  logic [W-1:0] height_i,
    output logic [W-1:0] x_o,
    output logic [W-1:0] y_o,
    output logic         last_o
);
    logic [W-1:0] x_q, y_q;
    logic         wrap;
    assign wrap   = x_q == width_i - W'(1);
    assign last_o = wrap && y_q == height_i - W'(1);
    assign x_o    = x_q;
    assign y_o    = y_q;
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            x_q <= '0;
            y_q <= '0;
        end else if (clear_i) begin
            x_q <= '0;
            y_q <= '0;
        end else if (step_i) begin
            x_q <= wrap ? '0 : x_q + W'(1);
            y_q <= wrap ? y_q + W'(1) : y_q;
        end
    end
endmodule

// File: rtl/line_buffer_sequencer.sv
// line_buffer_sequencer: frame sequencer driving the 2x2 line-buffer window stage
// clock/reset: system clock, async active-high reset
// cfg_width/cfg_height/cfg_load: shadow frame-size load; start: begin next frame
// bus: pixel input and line-buffer outputs; busy/cfg_error/dropped: status
// LINE_BUFFER_SEQ_STATS_EN adds drop_count (saturating) and frame_count (wrapping)
module line_buffer_sequencer
    import line_buffer_pkg::*;
#(
    parameter int N            = 8,
    parameter int FLUSH_CYCLES = 4,
    parameter int MIN_WIDTH    = MIN_WIDTH_DEF
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [COORD_W-1:0] cfg_width,
    input  logic [COORD_W-1:0] cfg_height,
    input  logic               cfg_load,
    input  logic               start,
    line_buffer_sequencer_if.slave bus,
    output logic               busy,
    output logic               cfg_error,
    output logic               dropped
`ifdef LINE_BUFFER_SEQ_STATS_EN
    ,
    output logic [STAT_W-1:0]  drop_count,
    output logic [STAT_W-1:0]  frame_count
`endif
);
    state_t             state_q;
    logic [COORD_W-1:0] sw_q, sh_q, aw_q, ah_q, cnt_q, lx_q, ly_q, x, y;
    logic [N-1:0]       data_q;
    logic               rstn_q, valid_q, done_q, err_q, drop_q;
    logic               last, cfg_ok, accept, discard, clear;
    assign cfg_ok  = cfg_width >= COORD_W'(MIN_WIDTH) && cfg_height >= COORD_W'(2);
    assign accept  = bus.in_valid && state_q == ACTIVE;
    assign discard = bus.in_valid && state_q != ACTIVE;
    assign clear   = state_q == FLUSH && cnt_q == '0;
    raster_counter #(.W(COORD_W)) u_raster (
        .clock    (clock),
        .reset    (reset),
        .clear_i  (clear),
        .step_i   (accept),
        .width_i  (aw_q),
        .height_i (ah_q),
        .x_o      (x),
        .y_o      (y),
        .last_o   (last)
    );
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            sw_q    <= COORD_W'(MIN_WIDTH);
            sh_q    <= COORD_W'(2);
            aw_q    <= COORD_W'(MIN_WIDTH);
            ah_q    <= COORD_W'(2);
            cnt_q   <= '0;
            lx_q    <= '0;
            ly_q    <= '0;
            data_q  <= '0;
            rstn_q  <= 1'b0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            valid_q <= accept;
            done_q  <= accept && last;
            drop_q  <= discard;
            if (accept) begin
                data_q <= bus.in_data;
                lx_q   <= x;
                ly_q   <= y;
            end
            if (cfg_load) begin
                err_q <= !cfg_ok;
                if (cfg_ok) begin
                    sw_q <= cfg_width;
                    sh_q <= cfg_height;
                end
            end
            case (state_q)
                IDLE: if (start) begin
                    // a legal load in the same cycle bypasses the shadow
                    state_q <= FLUSH;
                    aw_q    <= cfg_load && cfg_ok ? cfg_width : sw_q;
                    ah_q    <= cfg_load && cfg_ok ? cfg_height : sh_q;
                    cnt_q   <= COORD_W'(FLUSH_CYCLES - 1);
                end
                FLUSH: if (cnt_q == '0) begin
                    state_q <= ACTIVE;
                    rstn_q  <= 1'b1;
                end else begin
                    cnt_q <= cnt_q - COORD_W'(1);
                end
                ACTIVE: if (accept && last) begin
                    // two DONE cycles let the line buffer drain its done flag
                    state_q <= DONE;
                    cnt_q   <= COORD_W'(1);
                end
                DONE: if (cnt_q == '0) begin
                    state_q <= IDLE;
                    rstn_q  <= 1'b0;
                end else begin
                    cnt_q <= cnt_q - COORD_W'(1);
                end
            endcase
        end
    end
`ifdef LINE_BUFFER_SEQ_STATS_EN
    logic [STAT_W-1:0] dcnt_q, fcnt_q;
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            dcnt_q <= '0;
            fcnt_q <= '0;
        end else begin
            if (discard && ~&dcnt_q) dcnt_q <= dcnt_q + STAT_W'(1);
            if (accept && last) fcnt_q <= fcnt_q + STAT_W'(1);
        end
    end
    assign drop_count  = dcnt_q;
    assign frame_count = fcnt_q;
`endif
    assign bus.lb_reset_n = rstn_q;
    assign bus.lb_size    = aw_q;
    assign bus.lb_valid   = valid_q;
    assign bus.lb_data    = data_q;
    assign bus.lb_x       = lx_q;
    assign bus.lb_y       = ly_q;
    assign bus.lb_done    = done_q;
    assign busy           = state_q != IDLE;
    assign cfg_error      = err_q;
    assign dropped        = drop_q;
endmodule

// File: tb/tb_line_buffer_sequencer.sv
// tb_line_buffer_sequencer: scoreboard bench for line_buffer_sequencer
module tb_line_buffer_sequencer;
    typedef struct {
        int d;
        int x;
        int y;
        int done;
        int cyc;
    } ent_t;
    logic        clock = 0;
    logic        reset = 1;
    logic [11:0] cfg_width = 0;
    logic [11:0] cfg_height = 0;
    logic        cfg_load = 0;
    logic        start = 0;
    logic        busy, cfg_error, dropped;
`ifdef LINE_BUFFER_SEQ_STATS_EN
    logic [15:0] drop_count, frame_count;
`endif
    line_buffer_sequencer_if #(.N(8)) bus ();
    line_buffer_sequencer #(.N(8), .FLUSH_CYCLES(4), .MIN_WIDTH(3)) dut (
        .clock      (clock),
        .reset      (reset),
        .cfg_width  (cfg_width),
        .cfg_height (cfg_height),
        .cfg_load   (cfg_load),
        .start      (start),
        .bus        (bus),
        .busy       (busy),
        .cfg_error  (cfg_error),
        .dropped    (dropped)
`ifdef LINE_BUFFER_SEQ_STATS_EN
        ,
        .drop_count (drop_count),
        .frame_count(frame_count)
`endif
    );
    always #5 clock = ~clock;
    int   checks = 0, errors = 0, cyc = 0;
    int   exp_drops = 0, obs_drops = 0, stat_drops = 0, stat_frames = 0;
    ent_t sb[$];
    always @(posedge clock) cyc++;
    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
        end
    endtask
    always @(negedge clock) begin
        ent_t e;
        if (dropped) obs_drops++;
        if (bus.lb_valid) begin
            if (sb.size() == 0) chk("unexpected_lb_valid", 1, 0);
            else begin
                e = sb.pop_front();
                chk("lb_data", int'(bus.lb_data), e.d);
                chk("lb_x", int'(bus.lb_x), e.x);
                chk("lb_y", int'(bus.lb_y), e.y);
                chk("lb_done", int'(bus.lb_done), e.done);
                chk("latency", cyc, e.cyc);
            end
        end else if (bus.lb_done) chk("done_without_valid", 1, 0);
    end
    task automatic chk_reset_vals();
        chk("rst_lb_reset_n", int'(bus.lb_reset_n), 0);
        chk("rst_lb_valid", int'(bus.lb_valid), 0);
        chk("rst_lb_done", int'(bus.lb_done), 0);
        chk("rst_lb_data", int'(bus.lb_data), 0);
        chk("rst_lb_x", int'(bus.lb_x), 0);
        chk("rst_lb_y", int'(bus.lb_y), 0);
        chk("rst_lb_size", int'(bus.lb_size), 3);
        chk("rst_busy", int'(busy), 0);
        chk("rst_cfg_error", int'(cfg_error), 0);
        chk("rst_dropped", int'(dropped), 0);
`ifdef LINE_BUFFER_SEQ_STATS_EN
        chk("rst_drop_count", int'(drop_count), 0);
        chk("rst_frame_count", int'(frame_count), 0);
`endif
    endtask
    task automatic mid_reset();
        #1 reset = 1;
        #1 chk_reset_vals();
        stat_drops = 0;
        stat_frames = 0;
        @(negedge clock);
        reset = 0;
    endtask
    task automatic load(input int w, input int h);
        cfg_load = 1;
        cfg_width = 12'(w);
        cfg_height = 12'(h);
        @(negedge clock);
        cfg_load = 0;
    endtask
    task automatic do_start(input int size, input bit inject);
        start = 1;
        @(negedge clock);
        start = 0;
        cfg_load = 0;
        for (int i = 0; i < 4; i++) begin
            chk("flush_lb_reset_n", int'(bus.lb_reset_n), 0);
            chk("flush_busy", int'(busy), 1);
            bus.in_valid = inject && i == 1;
            bus.in_data = 8'h5A;
            if (inject && i == 1) begin
                exp_drops++;
                stat_drops++;
            end
            @(negedge clock);
        end
        bus.in_valid = 0;
        chk("active_lb_reset_n", int'(bus.lb_reset_n), 1);
        chk("lb_size", int'(bus.lb_size), size);
    endtask
    task automatic run_pixels(input int w, input int h, input int cnt,
                              input int load_at, input int lw, input int lh, input int start_at);
        ent_t e;
        for (int p = 0; p < cnt; p++) begin
            e.d = int'(8'(16 + p * 7));
            e.x = p % w;
            e.y = p / w;
            e.done = int'(p == w * h - 1);
            e.cyc = cyc + 1;
            bus.in_valid = 1;
            bus.in_data = 8'(e.d);
            cfg_load = p == load_at;
            cfg_width = 12'(lw);
            cfg_height = 12'(lh);
            start = p == start_at;
            sb.push_back(e);
            if (e.done != 0) stat_frames++;
            @(negedge clock);
        end
        bus.in_valid = 0;
        cfg_load = 0;
        start = 0;
    endtask
    task automatic finish_frame();
        bus.in_valid = 1;
        bus.in_data = 8'hAA;
        exp_drops++;
        stat_drops++;
        chk("done1_lb_reset_n", int'(bus.lb_reset_n), 1);
        chk("done1_busy", int'(busy), 1);
        @(negedge clock);
        bus.in_valid = 0;
        chk("done2_lb_reset_n", int'(bus.lb_reset_n), 1);
        chk("done2_busy", int'(busy), 1);
        @(negedge clock);
        chk("idle_busy", int'(busy), 0);
        chk("idle_lb_reset_n", int'(bus.lb_reset_n), 0);
    endtask
    initial begin
        bus.in_valid = 0;
        bus.in_data = 0;
        repeat (2) @(negedge clock);
        chk_reset_vals();
        reset = 0;
        @(negedge clock);
        load(640, 480);
        do_start(640, 1);
        chk("active_busy", int'(busy), 1);
        mid_reset();
        cfg_load = 1;
        cfg_width = 12'd4;
        cfg_height = 12'd3;
        do_start(4, 0);
        run_pixels(4, 3, 12, 6, 8, 2, 3);
        finish_frame();
        do_start(8, 1);
        run_pixels(8, 2, 16, -1, 0, 0, -1);
        finish_frame();
        load(2, 5);
        chk("cfg_error_set", int'(cfg_error), 1);
        do_start(8, 0);
        run_pixels(8, 2, 16, -1, 0, 0, -1);
        finish_frame();
        chk("cfg_error_sticky", int'(cfg_error), 1);
        load(4, 3);
        chk("cfg_error_clear", int'(cfg_error), 0);
`ifdef LINE_BUFFER_SEQ_STATS_EN
        chk("drop_count", int'(drop_count), stat_drops);
        chk("frame_count", int'(frame_count), stat_frames);
`endif
        do_start(4, 0);
        run_pixels(4, 3, 5, -1, 0, 0, -1);
        mid_reset();
        do_start(3, 0);
        run_pixels(3, 2, 6, -1, 0, 0, -1);
        finish_frame();
        repeat (2) @(negedge clock);
        chk("scoreboard_empty", sb.size(), 0);
        chk("dropped_pulses", obs_drops, exp_drops);
`ifdef LINE_BUFFER_SEQ_STATS_EN
        chk("drop_count_end", int'(drop_count), stat_drops);
        chk("frame_count_end", int'(frame_count), stat_frames);
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
